// File: rtl/demux_1to2_ls_pkg.sv
// Shared constants for the packet-aware 1:2 stream demux and its 2:1 mux sibling.
// Port codes match the in_sel encoding, and state codes match the two-state packet lock.
package demux_1to2_ls_pkg;

   localparam logic       PORT_A  = 1'b1;
   localparam logic       PORT_B  = 1'b0;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/demux_1to2_ls_skid_reg.sv
// One-entry output register slice with a valid/ready handshake.
// free reports that a beat can be captured this cycle (empty or draining).
module skid_reg_ls #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              last,
   input  logic              ready,
   output logic              free
);

   assign free = ~valid | ready;

   // stage p1: output register; data and last hold their value after a drain
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (ld) begin
         valid <= 1'b1;
         data  <= ld_data;
         last  <= ld_last;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_1to2_ls.sv
// Packet-aware 1:2 valid/ready demultiplexer: a packet's destination is taken from
// in_sel on its first beat and held until in_last; each output has one register slice.
module demux_1to2_ls
   import demux_1to2_ls_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   input  logic              in_sel,
   output logic              in_ready,
   output logic [DATA_W-1:0] a_data,
   output logic              a_valid,
   output logic              a_last,
   input  logic              a_ready,
   output logic [DATA_W-1:0] b_data,
   output logic              b_valid,
   output logic              b_last,
   input  logic              b_ready,
   output logic [CNT_W-1:0]  a_pkt_cnt,
   output logic [CNT_W-1:0]  b_pkt_cnt
);

   logic [0:0] state;
   logic       sel_q;
   logic       target;
   logic       a_free;
   logic       b_free;
   logic       accept;
   logic       ld_a;
   logic       ld_b;

   // Packet counters roll over rather than saturate.
   function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] v);
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // First beat routes straight from in_sel so a new packet costs no bubble.
   assign target   = (state == ST_IDLE) ? in_sel : sel_q;
   assign in_ready = (target == PORT_A) ? a_free : b_free;
   assign accept   = in_valid & in_ready;
   assign ld_a     = accept & (target == PORT_A);
   assign ld_b     = accept & (target == PORT_B);

   // stage p0: packet lock FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         sel_q <= 1'b0;
      end else if (accept) begin
         if (state == ST_IDLE) begin
            if (!in_last) begin
               sel_q <= in_sel;
               state <= ST_BUSY;
            end
         end else if (in_last) begin
            state <= ST_IDLE;
         end
      end
   end

   skid_reg_ls #(.DATA_W(DATA_W)) u_slot_a (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld_a),
      .ld_data (in_data),
      .ld_last (in_last),
      .data    (a_data),
      .valid   (a_valid),
      .last    (a_last),
      .ready   (a_ready),
      .free    (a_free)
   );

   skid_reg_ls #(.DATA_W(DATA_W)) u_slot_b (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld_b),
      .ld_data (in_data),
      .ld_last (in_last),
      .data    (b_data),
      .valid   (b_valid),
      .last    (b_last),
      .ready   (b_ready),
      .free    (b_free)
   );

   // stage p2: packets counted as their last beat leaves each output
   always_ff @(posedge clk) begin
      if (rst) begin
         a_pkt_cnt <= '0;
         b_pkt_cnt <= '0;
      end else begin
         if (a_valid && a_ready && a_last) a_pkt_cnt <= cnt_wrap_inc(a_pkt_cnt);
         if (b_valid && b_ready && b_last) b_pkt_cnt <= cnt_wrap_inc(b_pkt_cnt);
      end
   end

endmodule
